router_dst_port: RTL
====================

Name: router_dst_port

Overview:
- Parametrised destination-side output stage for the router: N independent per-destination FIFOs with a packet-end flag on every word.
- Each FIFO drives the vld_out / rd_enb / dout read handshake towards its destination.
- Successor to the fixed single 8-bit destination port, generalised in data width, FIFO depth and destination count.
- Adds a per-channel read-timeout flush (soft reset) and an end-of-packet marker.

Parameters:
- DW, 8: data word width in bits.
- DEPTH, 16: words per channel FIFO; power of 2, minimum 4.
- NCH, 3: number of destination channels, 2..8.
- TIMEOUT, 30: consecutive cycles with vld_out=1 and rd_enb=0 that trigger a flush.
- CW, $clog2(NCH): channel-select width.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- resetn  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe from router core.
- wr_ch  in  CW  destination channel for the write.
- din  in  DW  write data.
- din_last  in  1  marks din as the final word of a packet.
- full  out  NCH  per-channel FIFO full.
- dout  out  NCH*DW  per-channel read data; channel k occupies bits [k*DW +: DW].
- eop_out  out  NCH  per-channel end-of-packet flag aligned with dout.
- vld_out  out  NCH  per-channel FIFO not empty.
- rd_enb  in  NCH  per-channel read enable from destination.
- soft_reset  out  NCH  one-cycle pulse when a channel is flushed by timeout.

Behaviour:
- Reset (resetn=0, asynchronous): all pointers, counts and timeout counters = 0. Outputs: full=0, vld_out=0, dout=0, eop_out=0, soft_reset=0.
- Storage: per channel, DEPTH x (DW+1) entries {din_last, din}. Read and write pointers are log2(DEPTH) bits and wrap naturally. Occupancy count is log2(DEPTH)+1 bits.
- full[k] = (count==DEPTH); vld_out[k] = (count!=0). Both decode registered count, so they are valid the cycle after the causing edge.
- Write: with wr_en=1, the word goes into FIFO wr_ch if full[wr_ch]=0 at that edge.
  - Write to a full channel is dropped, including when that channel is read on the same edge.
  - wr_ch >= NCH: write ignored.
- Read: with rd_enb[k]=1 and vld_out[k]=1 at edge E, the head word is popped. dout/eop_out[k] show it from E+1 and hold until the next pop.
  - rd_enb[k] with vld_out[k]=0 has no effect.
  - 1-cycle read latency.
- Simultaneous read and write on a non-full, non-empty channel: count unchanged, both pointers advance.
- Write to an empty channel: vld_out goes high the next cycle. Read is not possible in the same cycle.
- Timeout counter per channel, width $clog2(TIMEOUT+1):
  - Increments each cycle with vld_out[k]=1 and rd_enb[k]=0.
  - Clears on rd_enb[k]=1 or vld_out[k]=0.
- Flush: on the edge where the counter would reach TIMEOUT:
  - pointers, count and counter clear; dout[k]/eop_out[k] go to 0;
  - soft_reset[k]=1 for exactly that following cycle;
  - a write to channel k on the flush edge is dropped.
- Reset mid-operation: all channels empty immediately, regardless of any in-progress packet.
- Channels are fully independent: a flush on k leaves the other channels untouched.

Test Plan:
- Reset then write 0xA5 (last=1) to ch1 -> vld_out=3'b010 next cycle. rd_enb[1] pulse -> dout[15:8]=0xA5 and eop_out[1]=1 one cycle later; vld_out[1]=0.
- Write 16 words 0x00..0x0F to ch0 -> full[0]=1. 17th write 0xFF dropped. Read 16 -> dout sequence 0x00..0x0F; vld_out[0] falls after the 16th pop.
- Ch2 full, same-edge write 0x77 and read -> read pops, write dropped, count=15. Next write accepted, order preserved across pointer wrap.
- Ch0 holds 3 words, rd_enb[0]=0 for 30 cycles -> soft_reset[0] pulses one cycle at cycle 30, vld_out[0]=0. Ch1 data unaffected.
- Rd_enb[0] asserted on cycle 29 of idle -> no flush, counter clears, word popped.
- Assert resetn=0 mid-packet with 5 words buffered on each channel -> all vld_out=0, dout=0 asynchronously. Post-release writes start at pointer 0.

Source files
------------

// File: rtl/router_dst_port.sv
// Destination-side output stage: NCH independent FIFOs with a per-word end-of-packet flag,
// a registered read port, and a per-channel flush when the destination stops reading.
module router_dst_port #(
  parameter int unsigned DW      = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned NCH     = 3,
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned CW      = $clog2(NCH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [CW-1:0]     wr_ch,
  input  logic [DW-1:0]     din,
  input  logic              din_last,
  output logic [NCH-1:0]    full,
  output logic [NCH*DW-1:0] dout,
  output logic [NCH-1:0]    eop_out,
  output logic [NCH-1:0]    vld_out,
  input  logic [NCH-1:0]    rd_enb,
  output logic [NCH-1:0]    soft_reset
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("router_dst_port: DEPTH must be a power of 2 and at least 4");
  end
  if (NCH < 2 || NCH > 8) begin : g_bad_nch
    $error("router_dst_port: NCH must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("router_dst_port: TIMEOUT must be at least 1");
  end

  // Out-of-range channel selects are discarded before the per-channel decode.
  logic wr_ok;
  assign wr_ok = wr_en && (32'(wr_ch) < NCH);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DW:0]   mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [DW:0]   head_q, head_d;
    logic          sr_q, sr_d;
    logic          vld, is_full, push, pop, flush;

    assign vld     = (cnt_q != '0);
    assign is_full = (cnt_q == (AW+1)'(DEPTH));
    assign pop     = vld && rd_enb[k];
    // Flush fires on the edge at which the stall counter would reach TIMEOUT.
    assign flush   = vld && !rd_enb[k] && (idle_q == TW'(TIMEOUT - 1));
    assign push    = wr_ok && (wr_ch == CW'(k)) && !is_full && !flush;

    always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      idle_d = idle_q;
      head_d = head_q;
      sr_d   = 1'b0;
      if (flush) begin
        wptr_d = '0;
        rptr_d = '0;
        cnt_d  = '0;
        idle_d = '0;
        head_d = '0;
        sr_d   = 1'b1;
      end else begin
        if (push) begin
          wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
          rptr_d = rptr_q + AW'(1);
          head_d = mem[rptr_q];
        end
        case ({push, pop})
          2'b10:   cnt_d = cnt_q + (AW+1)'(1);
          2'b01:   cnt_d = cnt_q - (AW+1)'(1);
          default: cnt_d = cnt_q;
        endcase
        idle_d = (vld && !rd_enb[k]) ? idle_q + TW'(1) : '0;
      end
    end

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
        idle_q <= '0;
        head_q <= '0;
        sr_q   <= 1'b0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
        idle_q <= idle_d;
        head_q <= head_d;
        sr_q   <= sr_d;
      end
    end

    // Storage needs no reset: contents are only visible through head_q after a pop.
    always_ff @(posedge clock) begin
      if (push) begin
        mem[wptr_q] <= {din_last, din};
      end
    end

    assign full[k]             = is_full;
    assign vld_out[k]          = vld;
    assign dout[k*DW +: DW]    = head_q[DW-1:0];
    assign eop_out[k]          = head_q[DW];
    assign soft_reset[k]       = sr_q;
  end

endmodule
